// File: rtl/rdma_retrans_wr_arbiter_pkg.sv
// Shared types and constants for the retransmission-buffer write arbiter.
package rdma_retrans_wr_arbiter_pkg;

  localparam int MEM_CMD_BITS = 96;
  localparam int AXI_NET_BITS = 512;
  localparam int BEAT_BYTES   = AXI_NET_BITS / 8;

  // Field layout inside a memory command
  localparam int CMD_ADDR_OFF = 0;
  localparam int CMD_LEN_OFF  = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CMD,
    ST_DATA
  } state_t;

endpackage

// File: rtl/rdma_retrans_wr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: first valid index at or
// after the pointer, wrapping around. Shared with the read-side arbiter.
module rdma_retrans_wr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_valid,
  input  logic [IW-1:0] i_ptr,
  output logic [IW-1:0] o_idx,
  output logic          o_found
);

  int w_pos;

  // Scan from farthest to nearest so the index closest to the pointer wins
  always_comb begin
    o_idx   = '0;
    o_found = 1'b0;
    w_pos   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = (int'(i_ptr) + k) % N;
      if (i_valid[w_pos]) begin
        o_idx   = IW'(w_pos);
        o_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rdma_retrans_wr_arbiter.sv
// Round-robin arbiter sharing the retransmission-buffer write path
// (command + data stream) between N_REQ requesters. The grant is held
// from command acceptance through the last data beat of the burst.
module rdma_retrans_wr_arbiter
  import rdma_retrans_wr_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int CMD_BITS  = MEM_CMD_BITS,
  parameter int DATA_BITS = AXI_NET_BITS,
  parameter int LEN_BITS  = 28,
  parameter int GW        = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  parameter int KEEP_BITS = DATA_BITS / 8
) (
  input  logic                       aclk,
  input  logic                       aresetn,
  input  logic [N_REQ-1:0]           s_req_valid,
  output logic [N_REQ-1:0]           s_req_ready,
  input  logic [N_REQ*CMD_BITS-1:0]  s_req_data,
  input  logic [N_REQ-1:0]           s_axis_tvalid,
  output logic [N_REQ-1:0]           s_axis_tready,
  input  logic [N_REQ*DATA_BITS-1:0] s_axis_tdata,
  input  logic [N_REQ*KEEP_BITS-1:0] s_axis_tkeep,
  input  logic [N_REQ-1:0]           s_axis_tlast,
  output logic                       m_req_valid,
  input  logic                       m_req_ready,
  output logic [CMD_BITS-1:0]        m_req_data,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [DATA_BITS-1:0]       m_axis_tdata,
  output logic [KEEP_BITS-1:0]       m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic [GW-1:0]              grant_id,
  output logic                       err_tlast
);

  localparam int CNT_W   = LEN_BITS - 5;
  localparam int BEAT_SH = $clog2(KEEP_BITS);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [GW-1:0]       r_grant;
  logic [GW-1:0]       r_rr_ptr;
  logic [CMD_BITS-1:0] r_cmd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_err;

  logic [GW-1:0]       w_pick_idx;
  logic                w_pick_found;
  logic [CMD_BITS-1:0] w_sel_cmd;
  logic [LEN_BITS:0]   w_len_sum;
  logic [CNT_W-1:0]    w_beats;
  logic                w_dat_hs;
  logic                w_last_beat;

  rdma_retrans_wr_arbiter_rr_pick #(
    .N  (N_REQ),
    .IW (GW)
  ) u_rr_pick (
    .i_valid (s_req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  // Beat count is ceil(len / beat size); the extra sum bit absorbs the carry
  assign w_sel_cmd   = s_req_data[w_pick_idx*CMD_BITS +: CMD_BITS];
  assign w_len_sum   = {1'b0, w_sel_cmd[CMD_LEN_OFF +: LEN_BITS]} + (LEN_BITS+1)'(KEEP_BITS - 1);
  assign w_beats     = CNT_W'(w_len_sum >> BEAT_SH);
  assign w_last_beat = (r_cnt == CNT_W'(1));
  assign w_dat_hs    = (r_state == ST_DATA) & s_axis_tvalid[r_grant] & m_axis_tready;
  assign grant_id    = r_grant;
  assign err_tlast   = r_err;

  // Next state plus granted-path muxing; everything idles at zero
  always_comb begin
    w_state_nxt   = r_state;
    m_req_valid   = 1'b0;
    m_req_data    = '0;
    s_req_ready   = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tkeep  = '0;
    m_axis_tlast  = 1'b0;
    s_axis_tready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_found) w_state_nxt = ST_CMD;
      end
      ST_CMD: begin
        m_req_valid          = 1'b1;
        m_req_data           = r_cmd;
        s_req_ready[r_grant] = m_req_ready;
        if (m_req_ready) w_state_nxt = (r_cnt != '0) ? ST_DATA : ST_IDLE;
      end
      ST_DATA: begin
        m_axis_tvalid          = s_axis_tvalid[r_grant];
        m_axis_tdata           = s_axis_tdata[r_grant*DATA_BITS +: DATA_BITS];
        m_axis_tkeep           = s_axis_tkeep[r_grant*KEEP_BITS +: KEEP_BITS];
        m_axis_tlast           = w_last_beat;
        s_axis_tready[r_grant] = m_axis_tready;
        if (w_dat_hs && w_last_beat) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Control state: FSM, grant owner, round-robin pointer, beat counter, error flag
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_IDLE && w_pick_found) begin
        r_grant <= w_pick_idx;
        r_cnt   <= w_beats;
      end
      if (r_state == ST_CMD && m_req_ready) begin
        r_rr_ptr <= (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
      end
      if (w_dat_hs) begin
        r_cnt <= r_cnt - 1'b1;
        if (s_axis_tlast[r_grant] != w_last_beat) r_err <= 1'b1;
      end
    end
  end

  // Command capture at grant time; held until the downstream handshake
  always_ff @(posedge aclk) begin
    if (r_state == ST_IDLE && w_pick_found) r_cmd <= w_sel_cmd;
  end

endmodule

// File: tb/tb_rdma_retrans_wr_arbiter.sv
// Self-checking bench for rdma_retrans_wr_arbiter with randomized traffic
// and a queue-based reference model of the arbitration rules.
module tb_rdma_retrans_wr_arbiter;
  import rdma_retrans_wr_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int CB = 96;
  localparam int DB = 512;
  localparam int KB = 64;
  localparam int GW = 2;

  logic            aclk;
  logic            aresetn;
  logic [N-1:0]    s_req_valid;
  logic [N-1:0]    s_req_ready;
  logic [N*CB-1:0] s_req_data;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N*DB-1:0] s_axis_tdata;
  logic [N*KB-1:0] s_axis_tkeep;
  logic [N-1:0]    s_axis_tlast;
  logic            m_req_valid;
  logic            m_req_ready;
  logic [CB-1:0]   m_req_data;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [DB-1:0]   m_axis_tdata;
  logic [KB-1:0]   m_axis_tkeep;
  logic            m_axis_tlast;
  logic [GW-1:0]   grant_id;
  logic            err_tlast;

  rdma_retrans_wr_arbiter #(
    .N_REQ(N), .CMD_BITS(CB), .DATA_BITS(DB), .LEN_BITS(28)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_req_data(s_req_data),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_data(m_req_data),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .grant_id(grant_id), .err_tlast(err_tlast)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int checks   = 0;
  int failures = 0;

  // Requester-side traffic: pending commands and their data beats
  logic [CB-1:0] cq  [N][$];
  logic [DB-1:0] dqd [N][$];
  logic [KB-1:0] dqk [N][$];
  bit            dql [N][$];

  // Reference model state
  int            m_ptr;
  bit            cmd_out;
  int            cur_req;
  logic [CB-1:0] cur_cmd;
  int            active_rem;
  int            owner;
  bit            m_err;
  logic [N-1:0]  prev_valid;
  int            grant_log[$];
  int            beats_log[$];
  int            beat_total;

  int req_rdy_pct  = 100;
  int axis_rdy_pct = 100;
  int tvalid_pct   = 100;
  bit axis_toggle  = 0;
  bit tog          = 0;
  bit scramble     = 1;

  function automatic int beats_of(logic [CB-1:0] c);
    int l;
    l = int'(c[CMD_LEN_OFF +: 28]);
    return (l + BEAT_BYTES - 1) / BEAT_BYTES;
  endfunction

  function automatic int rr_expect(logic [N-1:0] v, int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic bit busy();
    bit b;
    b = cmd_out || (active_rem != 0);
    for (int i = 0; i < N; i++) b = b || (cq[i].size() != 0) || (dqd[i].size() != 0);
    return b;
  endfunction

  task automatic enqueue(int r, int len, int bad_pos, int hi);
    logic [CB-1:0] c;
    int nb;
    c = '0;
    c[CMD_ADDR_OFF +: 64] = {$urandom, $urandom};
    c[CMD_LEN_OFF +: 32]  = {hi[3:0], len[27:0]};
    cq[r].push_back(c);
    nb = beats_of(c);
    for (int b = 1; b <= nb; b++) begin
      dqd[r].push_back({16{$urandom}});
      dqk[r].push_back({$urandom, $urandom});
      dql[r].push_back((bad_pos != 0) ? (b == bad_pos) : (b == nb));
    end
  endtask

  task automatic flush_model();
    for (int i = 0; i < N; i++) begin
      cq[i].delete(); dqd[i].delete(); dqk[i].delete(); dql[i].delete();
    end
    m_ptr = 0; cmd_out = 0; active_rem = 0; m_err = 0; prev_valid = '0;
    grant_log.delete(); beats_log.delete();
  endtask

  // One clock: drive requesters and sinks, check outputs against the model
  task automatic step_cycle();
    logic [N-1:0] dv, tv, exp_rdy;
    int e;
    @(negedge aclk);
    for (int i = 0; i < N; i++) begin
      dv[i] = (cq[i].size() > 0);
      if (dv[i] && !(scramble && cmd_out)) s_req_data[i*CB +: CB] = cq[i][0];
      else s_req_data[i*CB +: CB] = {$urandom, $urandom, $urandom};
      tv[i] = (dqd[i].size() > 0) && ($urandom_range(99) < tvalid_pct);
      if (tv[i]) begin
        s_axis_tdata[i*DB +: DB] = dqd[i][0];
        s_axis_tkeep[i*KB +: KB] = dqk[i][0];
        s_axis_tlast[i]          = dql[i][0];
      end else begin
        s_axis_tdata[i*DB +: DB] = {16{$urandom}};
        s_axis_tkeep[i*KB +: KB] = {$urandom, $urandom};
        s_axis_tlast[i]          = 1'($urandom_range(1));
      end
    end
    s_req_valid   = dv;
    s_axis_tvalid = tv;
    m_req_ready   = ($urandom_range(99) < req_rdy_pct);
    if (axis_toggle) begin
      m_axis_tready = tog;
      tog = !tog;
    end else begin
      m_axis_tready = ($urandom_range(99) < axis_rdy_pct);
    end
    #1;
    checks++;
    if (err_tlast !== m_err) begin
      failures++; $display("FAIL err_tlast: got %b want %b", err_tlast, m_err);
    end
    if (m_req_valid === 1'b1 && !cmd_out) begin
      e = rr_expect(prev_valid, m_ptr);
      checks++;
      if (e < 0 || active_rem != 0) begin
        failures++; $display("FAIL grant_pick: got grant %0d, model pick %0d, beats left %0d", grant_id, e, active_rem);
      end else begin
        cmd_out = 1; cur_req = e; cur_cmd = cq[e][0]; grant_log.push_back(e);
      end
    end
    if (cmd_out) begin
      exp_rdy = m_req_ready ? (N'(1) << cur_req) : '0;
      checks++;
      if (m_req_valid !== 1'b1 || m_req_data !== cur_cmd) begin
        failures++; $display("FAIL cmd_hold: got v=%b d=%h want v=1 d=%h", m_req_valid, m_req_data, cur_cmd);
      end
      checks++;
      if (s_req_ready !== exp_rdy || grant_id !== GW'(cur_req)) begin
        failures++; $display("FAIL cmd_ready: got rdy=%b gid=%0d want rdy=%b gid=%0d", s_req_ready, grant_id, exp_rdy, cur_req);
      end
    end else begin
      checks++;
      if (m_req_valid !== 1'b0 || s_req_ready !== '0) begin
        failures++; $display("FAIL cmd_idle: got v=%b rdy=%b want 0/0", m_req_valid, s_req_ready);
      end
    end
    if (active_rem > 0) begin
      exp_rdy = m_axis_tready ? (N'(1) << owner) : '0;
      checks++;
      if (m_axis_tvalid !== tv[owner] || s_axis_tready !== exp_rdy) begin
        failures++; $display("FAIL data_path: got v=%b rdy=%b want v=%b rdy=%b", m_axis_tvalid, s_axis_tready, tv[owner], exp_rdy);
      end
      if (tv[owner] && m_axis_tready) begin
        checks++;
        if (m_axis_tdata !== dqd[owner][0] || m_axis_tkeep !== dqk[owner][0] || m_axis_tlast !== (active_rem == 1)) begin
          failures++; $display("FAIL beat: got last=%b keep=%h data=%h want last=%b keep=%h data=%h",
                               m_axis_tlast, m_axis_tkeep, m_axis_tdata, (active_rem == 1), dqk[owner][0], dqd[owner][0]);
        end
        if (dql[owner][0] != (active_rem == 1)) m_err = 1;
        void'(dqd[owner].pop_front()); void'(dqk[owner].pop_front()); void'(dql[owner].pop_front());
        active_rem--; beat_total++;
      end
    end else begin
      checks++;
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== '0) begin
        failures++; $display("FAIL data_idle: got v=%b rdy=%b want 0/0", m_axis_tvalid, s_axis_tready);
      end
    end
    if (cmd_out && m_req_ready) begin
      void'(cq[cur_req].pop_front());
      m_ptr = (cur_req + 1) % N;
      active_rem = beats_of(cur_cmd);
      beats_log.push_back(active_rem);
      owner = cur_req;
      cmd_out = 0;
    end
    prev_valid = dv;
  endtask

  task automatic drain(int budget);
    int n = 0;
    while (busy() && n < budget) begin
      step_cycle();
      n++;
    end
    checks++;
    if (busy()) begin
      failures++; $display("FAIL drain_timeout: got still busy after %0d cycles want idle", n);
    end
    step_cycle();
    step_cycle();
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    s_req_valid = '0; s_req_data = '0; s_axis_tvalid = '0; s_axis_tdata = '0;
    s_axis_tkeep = '0; s_axis_tlast = '0; m_req_ready = 1'b0; m_axis_tready = 1'b0;
    flush_model();
    repeat (3) @(negedge aclk);
    #1;
    checks++;
    if ({m_req_valid, m_axis_tvalid, m_axis_tlast, err_tlast} !== 4'b0 || s_req_ready !== '0 ||
        s_axis_tready !== '0 || grant_id !== '0) begin
      failures++; $display("FAIL reset_state: got mv=%b av=%b err=%b rdy=%b trdy=%b gid=%0d want all 0",
                           m_req_valid, m_axis_tvalid, err_tlast, s_req_ready, s_axis_tready, grant_id);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    step_cycle();
  endtask

  task automatic test_single();
    int b0;
    req_rdy_pct = 100; axis_rdy_pct = 100; tvalid_pct = 100; axis_toggle = 0;
    grant_log.delete(); beats_log.delete(); b0 = beat_total;
    enqueue(1, 256, 0, 0);
    drain(200);
    checks++;
    if (grant_log.size() != 1 || grant_log[0] != 1 || beats_log[0] != 4 || beat_total - b0 != 4) begin
      failures++; $display("FAIL single: got grants=%p beats=%0d want grants={1} beats=4", grant_log, beat_total - b0);
    end
    // Pointer now at 2: requesters 0 and 2 together must go 2 first
    grant_log.delete();
    enqueue(0, 64, 0, 0);
    enqueue(2, 64, 0, 0);
    drain(200);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 2 || grant_log[1] != 0) begin
      failures++; $display("FAIL rr_ptr_after_single: got %p want {2,0}", grant_log);
    end
  endtask

  task automatic test_len_zero_and_rr();
    grant_log.delete(); beats_log.delete();
    enqueue(3, 0, 0, 0);
    drain(100);
    checks++;
    if (grant_log.size() != 1 || grant_log[0] != 3 || beats_log[0] != 0) begin
      failures++; $display("FAIL len_zero: got grants=%p beats=%p want {3} {0}", grant_log, beats_log);
    end
    grant_log.delete(); beats_log.delete();
    enqueue(0, 64, 0, 0); enqueue(2, 64, 0, 0); enqueue(3, 64, 0, 0);
    drain(300);
    checks++;
    if (grant_log.size() != 3 || grant_log[0] != 0 || grant_log[1] != 2 || grant_log[2] != 3) begin
      failures++; $display("FAIL rr_order: got %p want {0,2,3}", grant_log);
    end
  endtask

  task automatic test_tlast_err();
    enqueue(0, 100, 0, 0);
    drain(100);
    checks++;
    if (err_tlast !== 1'b0) begin
      failures++; $display("FAIL tlast_ok: got %b want 0", err_tlast);
    end
    enqueue(0, 100, 1, 0);
    drain(100);
    checks++;
    if (err_tlast !== 1'b1) begin
      failures++; $display("FAIL tlast_bad: got %b want 1", err_tlast);
    end
    enqueue(1, 64, 0, 0);
    drain(100);
    checks++;
    if (err_tlast !== 1'b1) begin
      failures++; $display("FAIL tlast_sticky: got %b want 1", err_tlast);
    end
  endtask

  task automatic test_backpressure();
    int hi_cnt = 0;
    int b0;
    beats_log.delete(); b0 = beat_total;
    req_rdy_pct = 0;
    enqueue(0, 512, 0, 0);
    repeat (6) begin
      step_cycle();
      if (m_req_valid === 1'b1) hi_cnt++;
    end
    checks++;
    if (hi_cnt != 5) begin
      failures++; $display("FAIL cmd_backpressure: got %0d valid cycles want 5", hi_cnt);
    end
    req_rdy_pct = 100; axis_toggle = 1;
    drain(200);
    axis_toggle = 0;
    checks++;
    if (beats_log.size() != 1 || beats_log[0] != 8 || beat_total - b0 != 8) begin
      failures++; $display("FAIL toggle_beats: got %0d want 8", beat_total - b0);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      req_rdy_pct  = $urandom_range(30, 100);
      axis_rdy_pct = $urandom_range(30, 100);
      tvalid_pct   = $urandom_range(40, 100);
      for (int k = 0; k < 8; k++) enqueue($urandom_range(N - 1), $urandom_range(300), 0, $urandom_range(15));
      drain(4000);
    end
    req_rdy_pct = 100; axis_rdy_pct = 100; tvalid_pct = 100;
  endtask

  task automatic test_reset_mid_burst();
    int n = 0;
    int b0;
    b0 = beat_total;
    enqueue(2, 512, 0, 0);
    while (beat_total - b0 < 3 && n < 60) begin
      step_cycle();
      n++;
    end
    checks++;
    if (beat_total - b0 != 3) begin
      failures++; $display("FAIL mid_burst_progress: got %0d beats want 3", beat_total - b0);
    end
    @(posedge aclk);
    #1;
    aresetn = 1'b0;
    #1;
    checks++;
    if ({m_req_valid, m_axis_tvalid, m_axis_tlast, err_tlast} !== 4'b0 || s_req_ready !== '0 ||
        s_axis_tready !== '0 || grant_id !== '0) begin
      failures++; $display("FAIL reset_mid: got mv=%b av=%b err=%b rdy=%b trdy=%b gid=%0d want all 0",
                           m_req_valid, m_axis_tvalid, err_tlast, s_req_ready, s_axis_tready, grant_id);
    end
    flush_model();
    s_req_valid = '0; s_axis_tvalid = '0; m_req_ready = 1'b0; m_axis_tready = 1'b0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    enqueue(1, 64, 0, 0);
    enqueue(3, 64, 0, 0);
    drain(200);
    checks++;
    if (grant_log.size() != 2 || grant_log[0] != 1 || grant_log[1] != 3) begin
      failures++; $display("FAIL post_reset_order: got %p want {1,3}", grant_log);
    end
  endtask

  initial begin
    beat_total = 0;
    test_reset();
    test_single();
    test_len_zero_and_rr();
    test_tlast_err();
    test_backpressure();
    test_random();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog");
  end

endmodule
